// File: rtl/dekatron_step_sequencer_if.sv
// Bundle between the DPC control FSM / Dekatron register bank (master side)
// and the step sequencer (slave side).
interface dekatron_step_sequencer_if #(
   parameter int DIGITS = 3
);
   // Handshake: Request is sampled only while Busy=0; an accepted Request
   // raises Busy on the same edge, Ack pulses for one cycle at completion and
   // Busy falls on the edge after Ack. Requests seen while Busy=1 are dropped.
   logic                   Request;
   logic                   Dec;
   logic                   Load;
   logic [10*DIGITS-1:0]   In;
   logic [10*DIGITS-1:0]   DigOut;
   logic [DIGITS-1:0]      PulseRight;
   logic [DIGITS-1:0]      PulseLeft;
   logic                   DekSet;
   logic [10*DIGITS-1:0]   DekIn;
   logic                   Busy;
   logic                   Ack;
   logic                   Carry;
   logic                   Fault;

   modport master (
      output Request, Dec, Load, In, DigOut,
      input  PulseRight, PulseLeft, DekSet, DekIn, Busy, Ack, Carry, Fault
   );

   modport slave (
      input  Request, Dec, Load, In, DigOut,
      output PulseRight, PulseLeft, DekSet, DekIn, Busy, Ack, Carry, Fault
   );
endinterface

// File: rtl/dekatron_step_sequencer.sv
// Drives a chain of Dekatron cells as a multi-digit decimal counter: one
// increment, decrement or parallel load per request, rippling carry/borrow.
module dekatron_step_sequencer #(
   parameter int DIGITS   = 3,
   parameter int PULSE_W  = 2,
   parameter int SETTLE_W = 1
) (
   input  logic                      Clk,
   input  logic                      Rst_n,
   dekatron_step_sequencer_if.slave  bus,
   output logic [2:0]                dbg_state_o
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAPTURE = 3'd1,
      PH1     = 3'd2,
      PH2     = 3'd3,
      SETTLE  = 3'd4,
      CHECK   = 3'd5,
      LOAD    = 3'd6,
      DONE    = 3'd7
   } state_e;

   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CMAX = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
   localparam int CW   = $clog2(CMAX + 1);

   state_e               state_q;
   logic [IW-1:0]        idx_q;
   logic [CW-1:0]        cnt_q;
   logic                 dec_q;
   logic                 wrap_q;
   logic [DIGITS-1:0]    pr_q;
   logic [DIGITS-1:0]    pl_q;
   logic                 dekset_q;
   logic [10*DIGITS-1:0] dekin_q;
   logic                 busy_q;
   logic                 ack_q;
   logic                 carry_q;
   logic                 fault_q;

   logic [9:0]           slice;
   logic                 slice_ok;
   logic [DIGITS-1:0]    idx_mask;

   assign slice    = bus.DigOut[int'(idx_q)*10 +: 10];
   assign slice_ok = (slice != 10'd0) && ((slice & (slice - 10'd1)) == 10'd0);
   assign idx_mask = DIGITS'(1) << idx_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         dec_q    <= 1'b0;
         wrap_q   <= 1'b0;
         pr_q     <= '0;
         pl_q     <= '0;
         dekset_q <= 1'b0;
         dekin_q  <= '0;
         busy_q   <= 1'b0;
         ack_q    <= 1'b0;
         carry_q  <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.Request) begin
                  dekin_q <= bus.In;
                  dec_q   <= bus.Dec;
                  carry_q <= 1'b0;
                  fault_q <= 1'b0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  if (bus.Load) begin
                     dekset_q <= 1'b1;
                     state_q  <= LOAD;
                  end else begin
                     state_q  <= CAPTURE;
                  end
               end
            end
            LOAD: begin
               dekset_q <= 1'b0;
               ack_q    <= 1'b1;
               state_q  <= DONE;
            end
            CAPTURE: begin
               if (!slice_ok) begin
                  fault_q <= 1'b1;
                  ack_q   <= 1'b1;
                  state_q <= DONE;
               end else begin
                  // Wrap means this digit will carry/borrow into the next one.
                  wrap_q  <= dec_q ? slice[0] : slice[9];
                  cnt_q   <= '0;
                  state_q <= PH1;
                  if (dec_q) pl_q <= idx_mask;
                  else       pr_q <= idx_mask;
               end
            end
            PH1: begin
               if (cnt_q == CW'(PULSE_W - 1)) begin
                  cnt_q   <= '0;
                  state_q <= PH2;
                  // Swapping the buses hands the pulse over without gap or overlap.
                  pr_q    <= pl_q;
                  pl_q    <= pr_q;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            PH2: begin
               if (cnt_q == CW'(PULSE_W - 1)) begin
                  cnt_q   <= '0;
                  pr_q    <= '0;
                  pl_q    <= '0;
                  state_q <= SETTLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            SETTLE: begin
               if (cnt_q == CW'(SETTLE_W - 1)) begin
                  cnt_q   <= '0;
                  state_q <= CHECK;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            CHECK: begin
               if (!slice_ok) begin
                  fault_q <= 1'b1;
                  ack_q   <= 1'b1;
                  state_q <= DONE;
               end else if (wrap_q && (idx_q != IW'(DIGITS - 1))) begin
                  idx_q   <= idx_q + 1'b1;
                  state_q <= CAPTURE;
               end else begin
                  carry_q <= wrap_q;
                  ack_q   <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               ack_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.PulseRight = pr_q;
   assign bus.PulseLeft  = pl_q;
   assign bus.DekSet     = dekset_q;
   assign bus.DekIn      = dekin_q;
   assign bus.Busy       = busy_q;
   assign bus.Ack        = ack_q;
   assign bus.Carry      = carry_q;
   assign bus.Fault      = fault_q;
   assign dbg_state_o    = state_q;

endmodule
